// File: rtl/rvfi_mem_fair_responder.sv
// Memory-side responder for core harnesses: NUM_CH independent valid/ready channels with
// bounded (or fixed) stall, per-channel protocol checking and transaction counting.
module rvfi_mem_fair_responder #(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 3,
    parameter int unsigned LATENCY  = 1,
    parameter int unsigned MODE     = 0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          req_valid_i,
    input  logic [NUM_CH-1:0]          req_we_i,
    input  logic [NUM_CH*ADDR_W-1:0]   req_addr_i,
    input  logic [NUM_CH-1:0]          stall_i,
    input  logic [NUM_CH*DATA_W-1:0]   rdata_src_i,
    output logic [NUM_CH-1:0]          ready_o,
    output logic [NUM_CH*DATA_W-1:0]   rdata_o,
    output logic [NUM_CH*4-1:0]        wait_cnt_o,
    output logic [NUM_CH*CNT_W-1:0]    txn_cnt_o,
    output logic [NUM_CH-1:0]          proto_err_o
);

    localparam int unsigned WC_W = 4;
    localparam logic [WC_W-1:0] MAX_WAIT_C = WC_W'(MAX_WAIT);
    localparam logic [WC_W-1:0] LAT_C      = WC_W'(LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Request attributes that must stay stable while a channel is stalled
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
    } req_t;

    // The stall counter field is only 4 bits wide
    if (MAX_WAIT > 15) begin : g_bad_max_wait
        $error("rvfi_mem_fair_responder: MAX_WAIT must be <= 15");
    end
    if (MODE > 1) begin : g_bad_mode
        $error("rvfi_mem_fair_responder: MODE must be 0 or 1");
    end
    if (MODE == 1 && LATENCY > MAX_WAIT) begin : g_bad_latency
        $error("rvfi_mem_fair_responder: LATENCY must be <= MAX_WAIT");
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_e             state_q, state_d;
        req_t               req_q, req_d, req_in;
        logic [WC_W-1:0]    wcnt_q, wcnt_d;
        logic               ready_q, ready_d;
        logic [DATA_W-1:0]  rdata_q, rdata_d;
        logic [CNT_W-1:0]   txn_q, txn_d;
        logic               err_q, err_d;
        logic               grant;
        logic               viol;

        assign req_in.we   = req_we_i[c];
        assign req_in.addr = req_addr_i[c*ADDR_W +: ADDR_W];

        // Grant condition: bounded nondeterministic stall or fixed latency
        always_comb begin
            grant = 1'b0;
            if (MODE == 1) begin
                grant = (wcnt_q == LAT_C);
            end else begin
                grant = !stall_i[c] || (wcnt_q == MAX_WAIT_C);
            end
        end

        assign viol = !req_valid_i[c] || (req_in != req_q);

        always_comb begin
            state_d = state_q;
            req_d   = req_q;
            wcnt_d  = wcnt_q;
            ready_d = 1'b0;
            rdata_d = rdata_q;
            txn_d   = txn_q;
            err_d   = err_q;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i[c]) begin
                        req_d   = req_in;
                        wcnt_d  = '0;
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A protocol violation aborts the request; it wins over a grant
                    if (viol) begin
                        err_d   = 1'b1;
                        wcnt_d  = '0;
                        state_d = ST_IDLE;
                    end else if (grant) begin
                        ready_d = 1'b1;
                        if (!req_q.we) begin
                            rdata_d = rdata_src_i[c*DATA_W +: DATA_W];
                        end
                        state_d = ST_RESP;
                    end else if (wcnt_q != MAX_WAIT_C) begin
                        wcnt_d = wcnt_q + WC_W'(1);
                    end
                end
                ST_RESP: begin
                    txn_d   = txn_q + CNT_W'(1);
                    wcnt_d  = '0;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                state_q <= ST_IDLE;
                req_q   <= '0;
                wcnt_q  <= '0;
                ready_q <= 1'b0;
                rdata_q <= '0;
                txn_q   <= '0;
                err_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                req_q   <= req_d;
                wcnt_q  <= wcnt_d;
                ready_q <= ready_d;
                rdata_q <= rdata_d;
                txn_q   <= txn_d;
                err_q   <= err_d;
            end
        end

        assign ready_o[c]                    = ready_q;
        assign rdata_o[c*DATA_W +: DATA_W]   = rdata_q;
        assign wait_cnt_o[c*WC_W +: WC_W]    = wcnt_q;
        assign txn_cnt_o[c*CNT_W +: CNT_W]   = txn_q;
        assign proto_err_o[c]                = err_q;
    end

endmodule

// File: tb/tb_rvfi_mem_fair_responder.sv
// Scoreboard bench: dut_a is MODE 0 (MAX_WAIT=3, CNT_W=4), dut_b is MODE 1 (LATENCY=2).
module tb_rvfi_mem_fair_responder;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
    } sb_t;

    logic        clock;
    logic        reset;
    logic [1:0]  valid [2];
    logic [1:0]  we    [2];
    logic [63:0] addr  [2];
    logic [63:0] src   [2];
    logic [1:0]  stall_a;
    logic [1:0]  stall_b;
    logic [1:0]  ready [2];
    logic [63:0] rdata [2];
    logic [7:0]  wcnt  [2];
    logic [1:0]  perr  [2];
    logic [7:0]  txn_a;
    logic [31:0] txn_b;

    int          cyc;
    int          n_checks;
    int          n_errors;
    sb_t         sbq [4][$];
    logic [31:0] mdl_rdata [2][2];
    int          mdl_txn [4];
    bit          pend [4];

    rvfi_mem_fair_responder #(
        .NUM_CH(2), .ADDR_W(32), .DATA_W(32), .MAX_WAIT(3), .LATENCY(1), .MODE(0), .CNT_W(4)
    ) dut_a (
        .clock(clock), .reset(reset),
        .req_valid_i(valid[0]), .req_we_i(we[0]), .req_addr_i(addr[0]),
        .stall_i(stall_a), .rdata_src_i(src[0]),
        .ready_o(ready[0]), .rdata_o(rdata[0]), .wait_cnt_o(wcnt[0]),
        .txn_cnt_o(txn_a), .proto_err_o(perr[0])
    );

    rvfi_mem_fair_responder #(
        .NUM_CH(2), .ADDR_W(32), .DATA_W(32), .MAX_WAIT(3), .LATENCY(2), .MODE(1), .CNT_W(16)
    ) dut_b (
        .clock(clock), .reset(reset),
        .req_valid_i(valid[1]), .req_we_i(we[1]), .req_addr_i(addr[1]),
        .stall_i(stall_b), .rdata_src_i(src[1]),
        .ready_o(ready[1]), .rdata_o(rdata[1]), .wait_cnt_o(wcnt[1]),
        .txn_cnt_o(txn_b), .proto_err_o(perr[1])
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        stall_b = 2'b00;
        forever begin
            @(posedge clock);
            #1;
            stall_b = 2'($urandom);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cyc=%0d)", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h exp=0x%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] txn_of(input int i);
        if (i < 2) return 64'(txn_a[i*4 +: 4]);
        return 64'(txn_b[(i-2)*16 +: 16]);
    endfunction

    // Drive one request at posedge+1 and push its expected completion to the scoreboard
    task automatic do_req(input int d, input int c, input bit w, input logic [31:0] a,
                          input logic [31:0] s, input int lat, input bit hold);
        sb_t e;
        int  n;
        valid[d][c]         = 1'b1;
        we[d][c]            = w;
        addr[d][c*32 +: 32] = a;
        src[d][c*32 +: 32]  = s;
        if (!w) mdl_rdata[d][c] = s;
        e.cyc   = cyc + 2 + lat;
        e.rdata = mdl_rdata[d][c];
        sbq[d*2+c].push_back(e);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!ready[d][c] && n < 40);
        check_eq($sformatf("d%0d_ch%0d_ready_seen", d, c), 64'(ready[d][c]), 64'd1);
        @(posedge clock);
        #1;
        if (!hold) valid[d][c] = 1'b0;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int d = 0; d < 2; d++) for (int c = 0; c < 2; c++) mdl_rdata[d][c] = '0;
    endtask

    // Monitor: pop the scoreboard on each ready pulse, then check the counter a cycle later
    initial begin : monitor
        sb_t e;
        for (int i = 0; i < 4; i++) begin
            mdl_txn[i] = 0;
            pend[i]    = 1'b0;
        end
        forever begin
            @(negedge clock);
            if (reset) begin
                for (int i = 0; i < 4; i++) begin
                    mdl_txn[i] = 0;
                    pend[i]    = 1'b0;
                end
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (pend[i]) begin
                        check_eq($sformatf("d%0d_ch%0d_txn_cnt", i/2, i%2), txn_of(i), 64'(mdl_txn[i]));
                        pend[i] = 1'b0;
                    end
                    if (ready[i/2][i%2]) begin
                        if (sbq[i].size() == 0) begin
                            check_eq($sformatf("d%0d_ch%0d_spurious_ready", i/2, i%2),
                                     64'(ready[i/2][i%2]), 64'd0);
                        end else begin
                            e = sbq[i].pop_front();
                            check_eq($sformatf("d%0d_ch%0d_ready_cycle", i/2, i%2), 64'(cyc), 64'(e.cyc));
                            check_eq($sformatf("d%0d_ch%0d_rdata", i/2, i%2),
                                     64'(rdata[i/2][(i%2)*32 +: 32]), 64'(e.rdata));
                            mdl_txn[i] = (mdl_txn[i] + 1) & ((i < 2) ? 15 : 65535);
                            pend[i]    = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin : main
        bit seen;
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        stall_a  = 2'b00;
        for (int d = 0; d < 2; d++) begin
            valid[d] = '0;
            we[d]    = '0;
            addr[d]  = '0;
            src[d]   = '0;
            for (int c = 0; c < 2; c++) mdl_rdata[d][c] = '0;
        end
        repeat (3) @(posedge clock);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("d%0d_rst_ready", d), 64'(ready[d]), 64'd0);
            check_eq($sformatf("d%0d_rst_rdata", d), rdata[d], 64'd0);
            check_eq($sformatf("d%0d_rst_wait_cnt", d), 64'(wcnt[d]), 64'd0);
            check_eq($sformatf("d%0d_rst_proto_err", d), 64'(perr[d]), 64'd0);
        end
        check_eq("d0_rst_txn", 64'(txn_a), 64'd0);
        check_eq("d1_rst_txn", 64'(txn_b), 64'd0);
        reset = 1'b0;

        // T1: permanent stall is cut off after MAX_WAIT cycles
        stall_a = 2'b11;
        do_req(0, 0, 1'b0, 32'h100, 32'hDEADBEEF, 3, 1'b0);
        check_eq("t1_txn", 64'(txn_a[3:0]), 64'd1);
        check_eq("t1_rdata_hold", 64'(rdata[0][31:0]), 64'hDEADBEEF);

        // T2: no stall, continuous valid, one transfer per 3 cycles
        reset_pulse();
        stall_a = 2'b00;
        for (int i = 0; i < 4; i++)
            do_req(0, 0, 1'b0, 32'h400 + 32'(4*i), 32'hA000_0000 + 32'(i), 0, i < 3);
        check_eq("t2_txn", 64'(txn_a[3:0]), 64'd4);

        // T4: ch1 write aborted by dropping valid while stalled
        do_req(0, 1, 1'b0, 32'h200, 32'h12345678, 0, 1'b0);
        stall_a = 2'b10;
        valid[0][1]      = 1'b1;
        we[0][1]         = 1'b1;
        addr[0][63:32]   = 32'h240;
        src[0][63:32]    = 32'h55AA55AA;
        @(posedge clock); #1;
        @(posedge clock); #1;
        valid[0][1] = 1'b0;
        @(posedge clock); #1;
        check_eq("t4_proto_err", 64'(perr[0][1]), 64'd1);
        repeat (3) @(posedge clock);
        #1;
        check_eq("t4_proto_err_sticky", 64'(perr[0][1]), 64'd1);
        check_eq("t4_ch0_no_err", 64'(perr[0][0]), 64'd0);
        check_eq("t4_rdata_unchanged", 64'(rdata[0][63:32]), 64'(mdl_rdata[0][1]));
        stall_a = 2'b00;
        do_req(0, 1, 1'b0, 32'h204, 32'hCAFEF00D, 0, 1'b0);
        check_eq("t4_err_after_ok", 64'(perr[0][1]), 64'd1);

        // T5: reset while ch0 is stalled with wait_cnt=2
        stall_a = 2'b01;
        valid[0][0]    = 1'b1;
        we[0][0]       = 1'b0;
        addr[0][31:0]  = 32'h300;
        src[0][31:0]   = 32'h0BADF00D;
        repeat (4) @(negedge clock);
        check_eq("t5_wait_cnt", 64'(wcnt[0][3:0]), 64'd2);
        reset       = 1'b1;
        valid[0][0] = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check_eq("t5_ready", 64'(ready[0]), 64'd0);
        check_eq("t5_rdata", rdata[0], 64'd0);
        check_eq("t5_wait_cnt_clr", 64'(wcnt[0]), 64'd0);
        check_eq("t5_txn", 64'(txn_a), 64'd0);
        check_eq("t5_proto_err", 64'(perr[0]), 64'd0);
        for (int d = 0; d < 2; d++) for (int c = 0; c < 2; c++) mdl_rdata[d][c] = '0;
        @(posedge clock); #1;
        reset = 1'b0;
        seen  = 1'b0;
        repeat (10) begin
            @(negedge clock);
            seen |= ready[0][0];
        end
        check_eq("t5_no_stale_ready", 64'(seen), 64'd0);
        @(posedge clock); #1;

        // T6: 16 transfers wrap the 4-bit counter
        stall_a = 2'b00;
        for (int i = 0; i < 16; i++)
            do_req(0, 0, (i % 3) == 0, 32'h800 + 32'(4*i), 32'hB000_0000 + 32'(i), 0, i < 15);
        check_eq("t6_txn_wrap", 64'(txn_a[3:0]), 64'd0);
        check_eq("t6_proto_err", 64'(perr[0]), 64'd0);

        // T3: fixed latency on both channels, staggered by one cycle, random stall ignored
        fork
            begin
                for (int i = 0; i < 5; i++)
                    do_req(1, 0, 1'b0, 32'h1000 + 32'(4*i), 32'($urandom), 2, i < 4);
            end
            begin
                @(posedge clock); #1;
                for (int i = 0; i < 5; i++)
                    do_req(1, 1, (i % 2) == 1, 32'h2000 + 32'(4*i), 32'($urandom), 2, i < 4);
            end
        join
        repeat (2) @(posedge clock);
        #1;
        check_eq("t3_ch0_txn", 64'(txn_b[15:0]), 64'd5);
        check_eq("t3_ch1_txn", 64'(txn_b[31:16]), 64'd5);
        check_eq("t3_proto_err", 64'(perr[1]), 64'd0);

        repeat (4) @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("sb%0d_drained", i), 64'(sbq[i].size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
